// File: rtl/conv_asd.sv
// rtl/conv_asd.sv - ASD to canonical signed-digit (NAF) converter with in-place digit memory
module conv_asd (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       weCsd,
  input  logic [3:0] address,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  output logic       Zi,
  output logic       Zcsd,
  output logic       done,
  output logic       Load,
  output logic       reCsd,
  output logic       enable,
  output logic       enCnt
);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, CONV, DONE} state_t;

  state_t             state;
  logic [7:0]         mem [16];
  logic signed [16:0] acc;
  logic [3:0]         cnt;

  logic signed [16:0] rd_digit;
  logic signed [16:0] csd_digit;
  logic [7:0]         csd_code;
  logic signed [16:0] acc_shift;

  // Odd residue picks +1 or -1 so the next digit up is forced to zero.
  always_comb begin
    rd_digit = '0;
    if (mem[cnt][7])
      rd_digit = -17'sd1;
    else if (mem[cnt] != 8'h00)
      rd_digit = 17'sd1;
    csd_digit = '0;
    csd_code  = 8'h00;
    if (acc[1:0] == 2'b01) begin
      csd_digit = 17'sd1;
      csd_code  = 8'h01;
    end else if (acc[1:0] == 2'b11) begin
      csd_digit = -17'sd1;
      csd_code  = 8'hFF;
    end
    acc_shift = (acc - csd_digit) >>> 1;
  end

  assign dataOut = mem[address];
  assign Zi      = (mem[cnt] == 8'h00);
  assign Zcsd    = (acc == 17'sd0);

  // Strobes are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      Load   <= 1'b0;
      reCsd  <= 1'b0;
      enable <= 1'b0;
      enCnt  <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      if (weCsd && (state == IDLE || state == DONE))
        mem[address] <= dataIn;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            Load  <= 1'b1;
          end
        end
        LOAD: begin
          acc    <= '0;
          cnt    <= 4'd14;
          state  <= ACCUM;
          Load   <= 1'b0;
          reCsd  <= 1'b1;
          enable <= 1'b1;
          enCnt  <= 1'b1;
        end
        ACCUM: begin
          acc <= (acc <<< 1) + rd_digit;
          if (cnt == 4'd0) begin
            state <= CONV;
            reCsd <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CONV: begin
          mem[cnt] <= csd_code;
          acc      <= acc_shift;
          if (cnt == 4'd15) begin
            state  <= DONE;
            done   <= 1'b1;
            enable <= 1'b0;
            enCnt  <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_asd.sv
// tb/tb_conv_asd.sv - self-checking bench for conv_asd with table vectors and a NAF reference model
module tb_conv_asd;

  logic       clk = 1'b0;
  logic       reset, start, weCsd;
  logic [3:0] address;
  logic [7:0] dataIn, dataOut;
  logic       Zi, Zcsd, done, Load, reCsd, enable, enCnt;

  int checks = 0;
  int errors = 0;

  conv_asd dut (
    .clk(clk), .reset(reset), .start(start), .weCsd(weCsd), .address(address),
    .dataIn(dataIn), .dataOut(dataOut), .Zi(Zi), .Zcsd(Zcsd), .done(done),
    .Load(Load), .reCsd(reCsd), .enable(enable), .enCnt(enCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [119:0] digits;
    logic [127:0] csd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_csd(input logic [119:0] d);
    int         v;
    int         m;
    logic [7:0] b;
    logic [127:0] r;
    v = 0;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      b = d[8*i +: 8];
      if (b[7]) v -= (1 << i);
      else if (b != 8'h00) v += (1 << i);
    end
    for (int i = 0; i < 16; i++) begin
      m = ((v % 4) + 4) % 4;
      if (m == 1) begin
        r[8*i +: 8] = 8'h01;
        v = (v - 1) / 2;
      end else if (m == 3) begin
        r[8*i +: 8] = 8'hFF;
        v = (v + 1) / 2;
      end else begin
        v = v / 2;
      end
    end
    return r;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    weCsd = 1'b1; address = a; dataIn = d;
    @(negedge clk);
    weCsd = 1'b0;
  endtask

  task automatic load_digits(input logic [119:0] d, input logic [7:0] top);
    for (int i = 0; i < 15; i++) wr(4'(i), d[8*i +: 8]);
    wr(4'd15, top);
  endtask

  task automatic read_all(output logic [127:0] r);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      #1;
      r[8*i +: 8] = dataOut;
    end
    @(negedge clk);
  endtask

  task automatic run(input bit wr_accum, output int lat, output int n_load, output int n_re,
                     output int n_en, output int n_cnt, output int n_zi_bad);
    lat = 0; n_load = 0; n_re = 0; n_en = 0; n_cnt = 0; n_zi_bad = 0;
    start = 1'b1;
    while (!done && lat < 100) begin
      if (wr_accum && reCsd) begin
        weCsd = 1'b1; address = 4'd2; dataIn = 8'h01;
      end else begin
        weCsd = 1'b0;
      end
      @(negedge clk);
      lat++;
      n_load += int'(Load);
      n_re   += int'(reCsd);
      n_en   += int'(enable);
      n_cnt  += int'(enCnt);
      if (reCsd && !Zi) n_zi_bad++;
    end
    weCsd = 1'b0;
    chk("latency", 128'(lat), 128'd33);
  endtask

  task automatic finish_run();
    chk("done_high", 128'(done), 128'd1);
    chk("zcsd_at_done", 128'(Zcsd), 128'd1);
    @(negedge clk);
    chk("done_held", 128'(done), 128'd1);
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", 128'(done), 128'd0);
  endtask

  logic [127:0] rb, exp_r;
  logic [119:0] rnd;
  logic [7:0]   byt;
  int lat, n_load, n_re, n_en, n_cnt, n_zi_bad, guard;

  initial begin
    tbl[0] = '{digits: 120'h01_00_01_01,    csd: 128'h01_00_FF_00_FF};
    tbl[1] = '{digits: 120'h01_01_01,       csd: 128'h01_00_00_FF};
    tbl[2] = '{digits: {15{8'h01}},         csd: {8'h01, {14{8'h00}}, 8'hFF}};
    tbl[3] = '{digits: 120'h01_00_FF,       csd: 128'h01_00_FF};
    tbl[4] = '{digits: 120'h0,              csd: 128'h0};

    reset = 1'b0; start = 1'b0; weCsd = 1'b0; address = '0; dataIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_strobes", 128'({Load, reCsd, enable, enCnt}), 128'd0);
    chk("rst_zcsd_zi", 128'({Zcsd, Zi}), 128'd3);
    read_all(rb);
    chk("rst_mem", rb, 128'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      load_digits(tbl[k].digits, 8'h7F);
      run(1'b0, lat, n_load, n_re, n_en, n_cnt, n_zi_bad);
      if (k == 4) chk("zi_zero_accum", 128'(n_zi_bad), 128'd0);
      finish_run();
      read_all(rb);
      chk($sformatf("table_csd[%0d]", k), rb, tbl[k].csd);
    end

    load_digits(tbl[0].digits, 8'h00);
    run(1'b1, lat, n_load, n_re, n_en, n_cnt, n_zi_bad);
    chk("load_cycles", 128'(n_load), 128'd1);
    chk("recsd_cycles", 128'(n_re), 128'd15);
    chk("enable_cycles", 128'(n_en), 128'd31);
    chk("encnt_cycles", 128'(n_cnt), 128'd31);
    finish_run();
    read_all(rb);
    chk("write_ignored_busy", rb, tbl[0].csd);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 15; i++) begin
        case ($urandom_range(0, 3))
          0: byt = 8'h00;
          1: byt = 8'h01;
          2: byt = 8'hFF;
          default: byt = 8'($urandom);
        endcase
        rnd[8*i +: 8] = byt;
      end
      load_digits(rnd, 8'($urandom));
      run(1'b0, lat, n_load, n_re, n_en, n_cnt, n_zi_bad);
      finish_run();
      read_all(rb);
      exp_r = ref_csd(rnd);
      chk($sformatf("rand_csd[%0d]", t), rb, exp_r);
    end

    load_digits(tbl[2].digits, 8'h00);
    start = 1'b1;
    guard = 0;
    while (!(enable && !reCsd) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_conv", 128'(guard < 100), 128'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_strobes", 128'({Load, reCsd, enable, enCnt}), 128'd0);
    chk("abort_zcsd_zi", 128'({Zcsd, Zi}), 128'd3);
    start = 1'b0;
    @(negedge clk);
    read_all(rb);
    chk("abort_mem", rb, 128'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_abort", 128'({Load, done}), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
